// File: rtl/bcd_updown_counter_n.sv
// Cascaded N-digit BCD up/down counter with parallel load, wrap or saturate
// boundary handling, and registered carry / load-error pulses.
module bcd_updown_counter_n #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter bit          SATURATE   = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    up_down_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] load_value_i,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic                    carry_o,
    output logic                    load_err_o,
    output logic                    zero_o
);

    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic                    carry_q, carry_d;
    logic                    load_err_q, load_err_d;

    logic [4*NUM_DIGITS-1:0] stepped;
    logic                    load_ok;
    logic                    run_nine;
    logic                    run_zero;
    logic [3:0]              nib;

    // Single-cycle cascade: run_nine/run_zero track whether all lower digits
    // sit at the roll-over value, so each digit decides independently.
    always_comb begin
        stepped  = digits_q;
        load_ok  = 1'b1;
        run_nine = 1'b1;
        run_zero = 1'b1;
        nib      = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib = digits_q[4*i +: 4];
            if (up_down_i && run_nine) begin
                stepped[4*i +: 4] = (nib == 4'd9) ? 4'd0 : nib + 4'd1;
            end else if (!up_down_i && run_zero) begin
                stepped[4*i +: 4] = (nib == 4'd0) ? 4'd9 : nib - 4'd1;
            end
            run_nine = run_nine & (nib == 4'd9);
            run_zero = run_zero & (nib == 4'd0);
            if (load_value_i[4*i +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
    end

    always_comb begin
        digits_d   = digits_q;
        carry_d    = 1'b0;
        load_err_d = 1'b0;
        if (load_i) begin
            if (load_ok) begin
                digits_d = load_value_i;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (enable_i) begin
            // After the loop, run_nine/run_zero mean the whole count is at a boundary.
            if ((up_down_i && run_nine) || (!up_down_i && run_zero)) begin
                carry_d = 1'b1;
                if (!SATURATE) begin
                    digits_d = stepped;
                end
            end else begin
                digits_d = stepped;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            digits_q   <= '0;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            digits_q   <= digits_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
        end
    end

    assign digits_o   = digits_q;
    assign carry_o    = carry_q;
    assign load_err_o = load_err_q;
    assign zero_o     = (digits_q == '0);

endmodule

// File: doc/bcd_updown_counter_n.md
BCD_UPDOWN_COUNTER_N -- requirements
Module: bcd_updown_counter_n

Interface
REQ-001 Parameter NUM_DIGITS, default 4, SHALL set the number of cascaded BCD digits (legal range 1..8).
REQ-002 Parameter SATURATE, default 0, SHALL select the boundary mode (0 = wrap, 1 = saturate at the boundary value).
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL change on its rising edge only.
REQ-004 Port rst, input, 1 bit, SHALL be the reset, synchronous and active-high.
REQ-005 Port enable, input, 1 bit, SHALL permit one count step per cycle when high.
REQ-006 Port up_down, input, 1 bit, SHALL select the direction (1 = count up, 0 = count down).
REQ-007 Port load, input, 1 bit, SHALL request a parallel load of load_value.
REQ-008 Port load_value, input, 4*NUM_DIGITS bits, SHALL carry the BCD value to load, with digit i in bits [4i+3:4i] and digit 0 as the LSD.
REQ-009 Port digits, output, 4*NUM_DIGITS bits, SHALL be the registered BCD count, using the same digit packing as load_value.
REQ-010 Port carry, output, 1 bit, SHALL be a registered one-cycle pulse flagging a boundary event.
REQ-011 Port load_err, output, 1 bit, SHALL be a registered one-cycle pulse flagging a rejected load.
REQ-012 Port zero, output, 1 bit, SHALL be combinational and high exactly when digits equals all zeros.

Function
REQ-013 Priority SHALL be rst > load > enable > hold; when none applies, digits hold, carry = 0 and load_err = 0.
REQ-014 A load with every nibble of load_value at 9 or below SHALL write digits on the same edge, with carry = 0 and load_err = 0, regardless of enable.
REQ-015 A load with any nibble above 9 SHALL leave digits unchanged, assert load_err for one cycle, and suppress counting in that cycle.
REQ-016 Counting up: digit 0 SHALL increment each step; digit i (i > 0) SHALL increment only when digits 0..i-1 are all 9; any incremented digit at 9 SHALL become 0; all updates SHALL complete in a single cycle with no ripple latency.
REQ-017 Counting down: digit 0 SHALL decrement each step; digit i SHALL decrement only when digits 0..i-1 are all 0; any decremented digit at 0 SHALL become 9; all updates SHALL complete in a single cycle.
REQ-018 Wrap mode, up step from all-9s: digits SHALL become all 0s, with carry = 1 in the next cycle.
REQ-019 Wrap mode, down step from all-0s: digits SHALL become all 9s, with carry = 1 in the next cycle.
REQ-020 Saturate mode, up step at all-9s or down step at all-0s: digits SHALL hold, with carry = 1 in the next cycle; carry SHALL re-pulse on every further enabled step that pushes against the boundary.
REQ-021 carry SHALL be 0 in every cycle not caused by REQ-018 to REQ-020.
REQ-022 Changing up_down between cycles SHALL take effect on the next enabled step, with no dead cycle.
REQ-023 digits SHALL never hold a non-BCD nibble after reset.
REQ-024 The design SHALL be fully synchronous, with no latches and no derived clocks.

Reset
REQ-025 On a clk edge with rst = 1: digits SHALL become all 0s, carry = 0 and load_err = 0, overriding a simultaneous load or enable.
REQ-026 Reset asserted mid-count SHALL take effect on that same edge; counting SHALL resume from 0 on the first enabled edge after rst deasserts.
REQ-027 zero SHALL read 1 in the cycle following reset.

Verification (NUM_DIGITS = 2 unless stated)
REQ-028 Wrap up: load 0x98, then enable with up_down = 1 for 2 cycles -> digits 0x99 then 0x00; carry = 1 only in the cycle after the 0x99 -> 0x00 step; zero = 1.
REQ-029 Wrap down: after reset, one down step -> digits 0x99 and carry = 1; next down step -> 0x98 and carry = 0.
REQ-030 Saturate (SATURATE = 1): load 0x99, then 3 up steps -> digits stay 0x99 and carry pulses each cycle; 1 down step -> 0x98, carry = 0.
REQ-031 Bad load: with digits = 0x42, load 0x3A with enable = 1 -> digits stay 0x42, load_err = 1 for exactly one cycle, and no count occurs.
REQ-032 Priority: rst = 1, load = 1 (0x55) and enable = 1 in the same cycle -> digits 0x00, carry = 0, load_err = 0; then load 0x55 with enable = 1 -> digits 0x55 (load beats count).
REQ-033 Cascade (NUM_DIGITS = 4): load 0x0999, then 1 up step -> 0x1000; then 1 down step -> 0x0999; carry stays 0 throughout.
